// File: rtl/ahb_csr_timer_if.sv
// CSR strobe bundle between the AHB-Lite slave front end and the timer register file.
interface ahb_csr_timer_if #(
  parameter int T_ADDR_WID = 8
);
  logic [T_ADDR_WID-1:0] T_ADDR;
  logic                  T_WREN;
  logic                  T_RDEN;
  logic [31:0]           T_WDATA;
  logic [2:0]            T_SIZE;
  logic [31:0]           T_RDATA;

  modport master (
    output T_ADDR, T_WREN, T_RDEN, T_WDATA, T_SIZE,
    input  T_RDATA
  );

  modport slave (
    input  T_ADDR, T_WREN, T_RDEN, T_WDATA, T_SIZE,
    output T_RDATA
  );
endinterface

// File: rtl/ahb_csr_timer.sv
// Prescaled 32-bit down-counting timer with auto-reload, sticky expiry flag and IRQ,
// plus scratch and ID registers, behind single-cycle CSR strobes.
module ahb_csr_timer #(
  parameter int          T_ADDR_WID = 8,
  parameter logic [31:0] ID_VALUE   = 32'h5449_4D31
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_csr_timer_if.slave   csr,
  output logic             IRQ
);

  logic [T_ADDR_WID-1:0] addr;
  logic [5:0]            word_sel;
  logic [3:0]            lane_en;

  logic        en_reg;
  logic        auto_reload_reg;
  logic        irq_en_reg;
  logic [7:0]  prescale_reg;
  logic [31:0] load_reg;
  logic [31:0] count_reg;
  logic        expired_reg;
  logic [31:0] scratch_reg;
  logic [7:0]  pcnt_reg;
  logic [31:0] rdata_reg;

  logic        en_next;
  logic [7:0]  pcnt_next;
  logic [31:0] rdata_next;
  logic [31:0] load_wr;
  logic [31:0] count_wr;
  logic [31:0] scratch_wr;

  logic wr_ctrl, wr_load, wr_count, wr_status, wr_scratch;
  logic tick, expire, status_clr, ctrl_lane0_wr;

  assign addr     = csr.T_ADDR;
  assign word_sel = addr[7:2];

  always_comb begin
    lane_en = 4'b0000;
    case (csr.T_SIZE)
      3'd0:    lane_en = 4'b0001 << addr[1:0];
      3'd1:    lane_en = addr[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  assign wr_ctrl    = csr.T_WREN && (word_sel == 6'h00);
  assign wr_load    = csr.T_WREN && (word_sel == 6'h01);
  assign wr_count   = csr.T_WREN && (word_sel == 6'h02) && (lane_en != 4'b0000);
  assign wr_status  = csr.T_WREN && (word_sel == 6'h03);
  assign wr_scratch = csr.T_WREN && (word_sel == 6'h04);

  // Byte-lane merge: disabled lanes keep their current contents.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign load_wr[8*gi +: 8]    = lane_en[gi] ? csr.T_WDATA[8*gi +: 8] : load_reg[8*gi +: 8];
      assign count_wr[8*gi +: 8]   = lane_en[gi] ? csr.T_WDATA[8*gi +: 8] : count_reg[8*gi +: 8];
      assign scratch_wr[8*gi +: 8] = lane_en[gi] ? csr.T_WDATA[8*gi +: 8] : scratch_reg[8*gi +: 8];
    end
  endgenerate

  assign tick          = en_reg && (pcnt_reg == prescale_reg);
  assign expire        = tick && (count_reg == 32'd0);
  assign ctrl_lane0_wr = wr_ctrl && lane_en[0];
  assign status_clr    = wr_status && lane_en[0] && csr.T_WDATA[0];

  // A CTRL write to EN takes priority over the one-shot auto-disable.
  always_comb begin
    en_next = en_reg;
    if (ctrl_lane0_wr)
      en_next = csr.T_WDATA[0];
    else if (expire && !auto_reload_reg)
      en_next = 1'b0;
  end

  // PCNT sits at 0 whenever the timer is or becomes disabled, and on a 0->1 enable.
  always_comb begin
    pcnt_next = 8'd0;
    if (en_reg && en_next && !tick)
      pcnt_next = pcnt_reg + 8'd1;
  end

  always_comb begin
    rdata_next = 32'd0;
    case (word_sel)
      6'h00:   rdata_next = {16'd0, prescale_reg, 5'd0, irq_en_reg, auto_reload_reg, en_reg};
      6'h01:   rdata_next = load_reg;
      6'h02:   rdata_next = count_reg;
      6'h03:   rdata_next = {31'd0, expired_reg};
      6'h04:   rdata_next = scratch_reg;
      6'h05:   rdata_next = ID_VALUE;
      default: rdata_next = 32'd0;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      en_reg          <= 1'b0;
      auto_reload_reg <= 1'b0;
      irq_en_reg      <= 1'b0;
      prescale_reg    <= 8'd0;
      load_reg        <= 32'd0;
      count_reg       <= 32'd0;
      expired_reg     <= 1'b0;
      scratch_reg     <= 32'd0;
      pcnt_reg        <= 8'd0;
      rdata_reg       <= 32'd0;
    end else begin
      en_reg   <= en_next;
      pcnt_reg <= pcnt_next;
      if (ctrl_lane0_wr) begin
        auto_reload_reg <= csr.T_WDATA[1];
        irq_en_reg      <= csr.T_WDATA[2];
      end
      if (wr_ctrl && lane_en[1])
        prescale_reg <= csr.T_WDATA[15:8];
      if (wr_load)
        load_reg <= load_wr;
      if (wr_scratch)
        scratch_reg <= scratch_wr;
      // A COUNT write beats both decrement and reload on a tick.
      if (wr_count)
        count_reg <= count_wr;
      else if (tick) begin
        if (count_reg != 32'd0)
          count_reg <= count_reg - 32'd1;
        else if (auto_reload_reg)
          count_reg <= load_reg;
      end
      expired_reg <= (expired_reg && !status_clr) || expire;
      // Read mux samples pre-write state, so a same-cycle write is not visible.
      if (csr.T_RDEN)
        rdata_reg <= rdata_next;
    end
  end

  assign csr.T_RDATA = rdata_reg;
  assign IRQ         = expired_reg & irq_en_reg;

endmodule

// File: tb/tb_ahb_csr_timer.sv
// Directed-vector bench for ahb_csr_timer; bus strobes launched on the falling edge.
module tb_ahb_csr_timer;

  logic HCLK;
  logic HRESET;
  logic IRQ;
  int   total;
  int   bad;
  logic [31:0] rd;

  ahb_csr_timer_if #(.T_ADDR_WID(8)) bus ();

  ahb_csr_timer #(.T_ADDR_WID(8), .ID_VALUE(32'h5449_4D31)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .csr    (bus),
    .IRQ    (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // All bus tasks are entered and left on a falling edge.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [2:0] sz);
    bus.T_ADDR  = a;
    bus.T_WDATA = d;
    bus.T_SIZE  = sz;
    bus.T_WREN  = 1'b1;
    @(negedge HCLK);
    bus.T_WREN  = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus.T_ADDR = a;
    bus.T_RDEN = 1'b1;
    @(negedge HCLK);
    bus.T_RDEN = 1'b0;
    d = bus.T_RDATA;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    HRESET      = 1'b1;
    bus.T_ADDR  = '0;
    bus.T_WREN  = 1'b0;
    bus.T_RDEN  = 1'b0;
    bus.T_WDATA = '0;
    bus.T_SIZE  = 3'd2;
    @(negedge HCLK);
    check("reset_rdata", bus.T_RDATA, 32'h0);
    check("reset_irq", {31'd0, IRQ}, 32'h0);
    HRESET = 1'b0;

    bus_read(8'h14, rd); check("id", rd, 32'h5449_4D31);
    bus_read(8'h00, rd); check("ctrl_reset", rd, 32'h0);

    // Byte-lane writes to SCRATCH
    bus_write(8'h10, 32'hA5A5_A5A5, 3'd2);
    bus_write(8'h12, 32'h003C_0000, 3'd0);
    bus_write(8'h10, 32'h0000_BEEF, 3'd1);
    bus_read(8'h10, rd); check("scratch_lanes", rd, 32'hA53C_BEEF);
    bus_write(8'h10, 32'hFFFF_FFFF, 3'd3);
    bus_read(8'h10, rd); check("scratch_size3", rd, 32'hA53C_BEEF);
    bus_write(8'h12, 32'h1234_0000, 3'd1);
    bus_read(8'h10, rd); check("scratch_hi_half", rd, 32'h1234_BEEF);

    // Simultaneous write and read returns the pre-write value
    bus.T_ADDR  = 8'h10;
    bus.T_WDATA = 32'h0;
    bus.T_SIZE  = 3'd2;
    bus.T_WREN  = 1'b1;
    bus.T_RDEN  = 1'b1;
    @(negedge HCLK);
    bus.T_WREN  = 1'b0;
    bus.T_RDEN  = 1'b0;
    check("rw_same_cycle", bus.T_RDATA, 32'h1234_BEEF);
    idle(2);
    check("rdata_hold", bus.T_RDATA, 32'h1234_BEEF);
    bus_read(8'h10, rd); check("scratch_after_rw", rd, 32'h0);

    bus_write(8'h18, 32'hDEAD_BEEF, 3'd2);
    bus_read(8'h18, rd); check("unmapped", rd, 32'h0);

    // Auto-reload period 4 with IRQ
    bus_write(8'h04, 32'd3, 3'd2);
    bus_read(8'h04, rd); check("load_rb", rd, 32'd3);
    bus_write(8'h08, 32'd3, 3'd2);
    bus_write(8'h00, 32'h0000_0007, 3'd2);
    idle(3);
    check("irq_before_exp", {31'd0, IRQ}, 32'h0);
    idle(1);
    check("irq_first_exp", {31'd0, IRQ}, 32'h1);
    bus_write(8'h0C, 32'h1, 3'd2);
    check("irq_after_w1c", {31'd0, IRQ}, 32'h0);
    idle(2);
    check("irq_before_2nd", {31'd0, IRQ}, 32'h0);
    idle(1);
    check("irq_2nd_exp", {31'd0, IRQ}, 32'h1);

    // One-shot, PRESCALE=2
    bus_write(8'h00, 32'h0, 3'd2);
    bus_write(8'h0C, 32'h1, 3'd2);
    bus_write(8'h08, 32'd1, 3'd2);
    bus_write(8'h00, 32'h0000_0201, 3'd2);
    idle(2);
    bus_read(8'h08, rd); check("oneshot_cnt_pre", rd, 32'd1);
    bus_read(8'h08, rd); check("oneshot_cnt_zero", rd, 32'd0);
    bus_read(8'h0C, rd); check("oneshot_not_exp", rd, 32'd0);
    idle(1);
    bus_read(8'h0C, rd); check("oneshot_exp", rd, 32'd1);
    bus_read(8'h00, rd); check("oneshot_en_clr", rd, 32'h0000_0200);
    check("oneshot_no_irq", {31'd0, IRQ}, 32'h0);

    // W1C on the expiry cycle, then COUNT write on a tick
    bus_write(8'h0C, 32'h1, 3'd2);
    bus_write(8'h04, 32'd3, 3'd2);
    bus_write(8'h08, 32'd3, 3'd2);
    bus_write(8'h00, 32'h0000_0003, 3'd2);
    idle(3);
    bus_write(8'h0C, 32'h1, 3'd2);
    bus_read(8'h0C, rd); check("w1c_vs_set", rd, 32'd1);
    bus_write(8'h08, 32'h10, 3'd2);
    bus_read(8'h08, rd); check("count_wr_on_tick", rd, 32'h10);

    // Asynchronous reset mid-count with IRQ high
    bus_write(8'h00, 32'h0, 3'd2);
    bus_write(8'h0C, 32'h1, 3'd2);
    bus_write(8'h08, 32'd0, 3'd2);
    bus_write(8'h00, 32'h0000_0007, 3'd2);
    idle(1);
    check("irq_pre_reset", {31'd0, IRQ}, 32'h1);
    bus_read(8'h14, rd);
    #2 HRESET = 1'b1;
    #1;
    check("rst_irq", {31'd0, IRQ}, 32'h0);
    check("rst_rdata", bus.T_RDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    bus_read(8'h08, rd); check("rst_count", rd, 32'h0);
    bus_read(8'h00, rd); check("rst_ctrl", rd, 32'h0);
    bus_read(8'h04, rd); check("rst_load", rd, 32'h0);
    bus_read(8'h0C, rd); check("rst_status", rd, 32'h0);
    bus_read(8'h10, rd); check("rst_scratch", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
